// File: rtl/noc_pkg.sv
// Shared NoC definitions: tx state encoding, flit layout
// and 2-phase handshake constants.
package noc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    WAIT_ACK,
    DONE
  } tx_state_t;

  localparam int FLIT_W   = 8;
  localparam int HEAD_BIT = FLIT_W - 1;

  // Both ends of a 2-phase channel start from this level.
  localparam logic PH_INIT = 1'b0;
  localparam logic PH_FLIP = 1'b1;

endpackage

// File: rtl/phase_detect.sv
// Turns a 2-phase toggle line into a one-cycle event pulse.
// Shared by the tx ack path and the rx req path.
import noc_pkg::*;

module phase_detect (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic ev
);

  logic old;

  always_ff @(posedge clk) begin
    if (reset) old <= PH_INIT;
    else       old <= tog;
  end

  assign ev = tog ^ old;

endmodule

// File: rtl/tx.sv
// Router output-port transmit stage: reads a packet from the
// buffer and sends it flit by flit over a 2-phase channel.
import noc_pkg::*;

module tx #(
  parameter int SIZE      = 8,
  parameter int BUFF_BITS = 3,
  parameter int PKT_FLITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pkt_valid,
  output logic                 pkt_done,
  output logic                 busy,
  output logic [BUFF_BITS-1:0] buf_addr,
  input  logic [SIZE-1:0]      buf_data,
  output logic                 ch_req,
  output logic [SIZE-1:0]      ch_flit,
  input  logic                 ch_ack,
  output logic                 proto_err
);

  localparam logic [BUFF_BITS-1:0] LAST =
    BUFF_BITS'(PKT_FLITS - 1);

  tx_state_t            state;
  tx_state_t            nxt;
  logic [BUFF_BITS-1:0] flit_idx;
  logic                 ack_ev;
  logic                 last;

  phase_detect u_ack (
    .clk   (clk),
    .reset (reset),
    .tog   (ch_ack),
    .ev    (ack_ev)
  );

  assign last = (flit_idx == LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:     if (pkt_valid) nxt = FETCH;
      FETCH:    nxt = LOAD;
      LOAD:     nxt = SEND;
      SEND:     nxt = WAIT_ACK;
      WAIT_ACK: if (ack_ev) nxt = last ? DONE : FETCH;
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flit_idx  <= '0;
      buf_addr  <= '0;
      ch_req    <= PH_INIT;
      ch_flit   <= '0;
      pkt_done  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      pkt_done <= (state == DONE);
      if (ack_ev && state != WAIT_ACK)
        proto_err <= 1'b1;
      if (state == IDLE && pkt_valid) begin
        flit_idx <= '0;
        buf_addr <= '0;
      end
      // Head marker is rewritten, never taken from the buffer.
      if (state == LOAD)
        ch_flit <= {(flit_idx == '0), buf_data[SIZE-2:0]};
      if (state == SEND)
        ch_req <= ch_req ^ PH_FLIP;
      if (state == WAIT_ACK && ack_ev && !last) begin
        flit_idx <= flit_idx + 1'b1;
        buf_addr <= flit_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tx.sv
// Self-checking bench for tx: timing-level packet model,
// downstream ack responder and directed scenarios.
module tb_tx;

  localparam int N = 8;

  logic       clk = 0;
  logic       reset = 1;
  logic       pkt_valid = 0;
  logic       ch_ack = 0;
  logic       pkt_done;
  logic       busy;
  logic       ch_req;
  logic       proto_err;
  logic [2:0] buf_addr;
  logic [7:0] buf_data;
  logic [7:0] ch_flit;
  logic [7:0] mem [N];

  always #5 clk = ~clk;

  tx #(.SIZE(8), .BUFF_BITS(3), .PKT_FLITS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .pkt_valid (pkt_valid),
    .pkt_done  (pkt_done),
    .busy      (busy),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .ch_req    (ch_req),
    .ch_flit   (ch_flit),
    .ch_ack    (ch_ack),
    .proto_err (proto_err)
  );

  // Registered buffer read port.
  always @(posedge clk) buf_data <= mem[buf_addr];

  // Downstream rx: answers each req toggle after 0..10 cycles.
  int stray_n = 0;
  int stray_d = 0;
  int acks = 0;
  int cnt = 0;
  bit pend = 0;
  bit req_seen = 0;
  bit rnd = 0;

  always @(negedge clk) begin
    if (reset) begin
      ch_ack = 0;
      req_seen = 0;
      pend = 0;
    end else if (stray_n != stray_d) begin
      stray_d = stray_n;
      ch_ack = ~ch_ack;
    end else begin
      if (ch_req !== req_seen) begin
        req_seen = ch_req;
        pend = 1;
        cnt = rnd ? int'($urandom_range(10, 0)) : 0;
      end
      if (pend) begin
        if (cnt == 0) begin
          ch_ack = ~ch_ack;
          pend = 0;
          acks++;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Timing model: after acceptance or an ack, the flit appears
  // 2 cycles later and its req toggle 3 cycles later; the last
  // ack is followed by a done pulse one cycle after.
  int         cyc = 0;
  bit         m_armed = 0;
  bit         m_act = 0;
  bit         m_wait = 0;
  bit         m_fin = 0;
  bit         m_req = 0;
  bit         m_done = 0;
  bit         m_err = 0;
  bit         m_prev = 0;
  int         m_k = 0;
  int         m_t = 0;
  logic [7:0] m_flit = 0;
  logic [2:0] m_addr = 0;

  always @(posedge clk) begin : mdl
    bit ev;
    cyc++;
    ev = (ch_ack != m_prev);
    m_prev = ch_ack;
    m_done = 0;
    if (reset) begin
      m_armed = 1; m_act = 0; m_wait = 0; m_fin = 0;
      m_req = 0; m_err = 0; m_prev = 0; m_k = 0;
      m_flit = 0; m_addr = 0;
    end else begin
      if (ev && !m_wait) m_err = 1;
      if (m_fin) begin
        m_fin = 0; m_act = 0; m_done = 1;
      end else if (!m_act) begin
        if (pkt_valid) begin
          m_act = 1; m_k = 0; m_t = 0; m_addr = 0;
        end
      end else if (m_wait) begin
        if (ev) begin
          m_wait = 0;
          if (m_k == N - 1) m_fin = 1;
          else begin
            m_k++; m_t = 0; m_addr = 3'(m_k);
          end
        end
      end else begin
        m_t++;
        if (m_t == 2) m_flit = {m_k == 0, mem[m_k][6:0]};
        if (m_t == 3) begin
          m_req = ~m_req;
          m_wait = 1;
        end
      end
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         toggles = 0;
  int         dones = 0;
  int         last_done = 0;
  logic       prev_req = 0;
  logic [7:0] flits [$];

  task automatic tick();
    @(negedge clk);
    if (m_armed) begin
      checks++;
      if ({ch_req, ch_flit, busy, pkt_done, proto_err, buf_addr} !==
          {m_req, m_flit, m_act, m_done, m_err, m_addr}) begin
        errors++;
        $display("FAIL model cyc %0d: dut req=%b flit=%h busy=%b done=%b err=%b addr=%0d / want req=%b flit=%h busy=%b done=%b err=%b addr=%0d",
                 cyc, ch_req, ch_flit, busy, pkt_done, proto_err, buf_addr,
                 m_req, m_flit, m_act, m_done, m_err, m_addr);
      end
    end
    if (ch_req !== prev_req) begin
      toggles++;
      flits.push_back(ch_flit);
      prev_req = ch_req;
    end
    if (pkt_done === 1'b1) begin
      dones++;
      last_done = cyc;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_dones(input int target, input int limit);
    int n = 0;
    while (dones < target && n < limit) begin
      tick();
      n++;
    end
    chk("done_timeout", int'(dones >= target), 1);
  endtask

  function automatic int flit_at(input int i);
    if (i < flits.size()) return int'(flits[i]);
    return -1;
  endfunction

  task automatic start_pkt();
    pkt_valid = 1;
    tick();
    pkt_valid = 0;
  endtask

  initial begin
    int t0, d0, base, acc, a0, n, d1, b;
    for (int i = 0; i < N; i++) mem[i] = 8'h10 + 8'(i);

    // Reset
    reset = 1;
    tick();
    tick();
    chk("rst_req", ch_req, 0);
    chk("rst_flit", ch_flit, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", proto_err, 0);
    chk("rst_addr", buf_addr, 0);
    reset = 0;
    tick();

    // Single packet, zero-delay ack
    rnd = 0;
    t0 = toggles; d0 = dones; base = flits.size();
    acc = cyc + 1;
    start_pkt();
    wait_dones(d0 + 1, 200);
    chk("t2_latency", last_done - acc, 33);
    chk("t2_toggles", toggles - t0, 8);
    for (int i = 0; i < N; i++)
      chk($sformatf("t2_flit%0d", i), flit_at(base + i),
          (i == 0) ? 'h90 : 'h10 + i);
    tick(); tick(); tick();
    chk("t2_dones", dones - d0, 1);

    // Random ack delay
    rnd = 1;
    t0 = toggles; d0 = dones; base = flits.size();
    start_pkt();
    wait_dones(d0 + 1, 600);
    tick(); tick(); tick();
    chk("t3_toggles", toggles - t0, 8);
    chk("t3_dones", dones - d0, 1);
    chk("t3_head", flit_at(base), 'h90);
    chk("t3_tail", flit_at(base + 7), 'h17);

    // Spurious ack while idle
    rnd = 0;
    tick();
    @(posedge clk);
    stray_n++;
    tick();
    tick();
    chk("t4_err_set", proto_err, 1);
    t0 = toggles; d0 = dones;
    start_pkt();
    wait_dones(d0 + 1, 200);
    tick();
    chk("t4_toggles", toggles - t0, 8);
    chk("t4_err_sticky", proto_err, 1);

    // Reset mid-packet after the 3rd ack
    a0 = acks;
    start_pkt();
    n = 0;
    while (acks - a0 < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_acks", int'(acks - a0 >= 3), 1);
    reset = 1;
    tick();
    chk("t5_req", ch_req, 0);
    chk("t5_flit", ch_flit, 0);
    chk("t5_busy", busy, 0);
    chk("t5_addr", buf_addr, 0);
    chk("t5_done", pkt_done, 0);
    chk("t5_err", proto_err, 0);
    tick();
    reset = 0;
    tick();
    t0 = toggles; d0 = dones; base = flits.size();
    start_pkt();
    wait_dones(d0 + 1, 200);
    chk("t5_head", flit_at(base), 'h90);
    chk("t5_toggles", toggles - t0, 8);

    // Back-to-back packets
    tick();
    t0 = toggles; d0 = dones;
    pkt_valid = 1;
    wait_dones(d0 + 1, 200);
    d1 = last_done;
    b = -1;
    n = 0;
    while (b < 0 && n < 10) begin
      tick();
      if (busy === 1'b1) b = cyc;
      n++;
    end
    pkt_valid = 0;
    wait_dones(d0 + 2, 200);
    tick(); tick(); tick();
    chk("t6_gap", b - d1, 1);
    chk("t6_period", last_done - d1, 34);
    chk("t6_toggles", toggles - t0, 16);
    chk("t6_dones", dones - d0, 2);
    chk("t6_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
